// File: rtl/cs_pkg.sv
// Shared definitions for the control sequencer: IR field layout, opcodes,
// ALU select codes, FSM state encoding and opcode classes.
package cs_pkg;

    localparam int unsigned IR_W     = 32;
    localparam int unsigned OP_W     = 5;
    localparam int unsigned REGSEL_W = 4;
    localparam int unsigned ALU_W    = 4;

    // IR field bit positions
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RA_MSB = 26;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_MSB = 22;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_MSB = 18;
    localparam int unsigned RC_LSB = 15;
    localparam int unsigned C_MSB  = 18;
    localparam int unsigned C_LSB  = 0;

    // Opcodes
    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // ALU select codes
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_AND = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SHR = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SHL = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_ROR = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_ROL = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_MUL = 4'b1011;
    localparam logic [ALU_W-1:0] ALU_DIV = 4'b1100;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_e;

    // Execute-phase behaviour groups
    typedef enum logic [3:0] {
        CL_ALU, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV,
        CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILL
    } op_class_e;

endpackage

// File: rtl/reg_select_decoder.sv
// Register-field decoder: 4-bit register number plus enable -> one-hot strobe vector.
module reg_select_decoder #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned SEL_W = 4
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [NREGS-1:0] onehot_o
);

    // One bit at most; selections beyond NREGS produce no strobe
    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (en_i && (sel_i == SEL_W'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch, decode IR and step T-states for the datapath.
// Outputs are Moore-decoded from the state register and the live IR fields.
// Optional build macro CS_MEM_WAIT_EN adds mem_ready to stretch memory states.
module control_sequencer
    import cs_pkg::*;
#(
    parameter int unsigned NREGS = 16,
    parameter int unsigned OPW   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef CS_MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    input  logic [IR_W-1:0]    IR,
    input  logic               stop,
    output logic [NREGS-1:0]   r_in,
    output logic [NREGS-1:0]   r_out,
    output logic               PCout,
    output logic               PC_in,
    output logic               Inc_PC,
    output logic               MAR_in,
    output logic               MDR_in,
    output logic               MDRout,
    output logic               IR_in,
    output logic               Y_in,
    output logic               Z_in,
    output logic               ZLOWout,
    output logic               ZHIout,
    output logic               HI_in,
    output logic               LO_in,
    output logic               HIout,
    output logic               LOout,
    output logic               Cout,
    output logic               read,
    output logic               write,
    output logic [ALU_W-1:0]   ALU_select,
    output logic               run,
    output logic               illegal_op
);

    state_e                state_q, state_d;
    op_class_e             op_cls;
    logic [OPW-1:0]        op;
    logic [REGSEL_W-1:0]   ra, rb, rc;
    logic [ALU_W-1:0]      alu_code;
    logic                  rin_en, rout_en;
    logic [REGSEL_W-1:0]   rin_sel, rout_sel;
    logic                  mem_ok;
    state_e                inst_end;
    logic                  unused_ir;

    assign op = IR[OP_MSB -: OPW];
    assign ra = IR[RA_MSB:RA_LSB];
    assign rb = IR[RB_MSB:RB_LSB];
    assign rc = IR[RC_MSB:RC_LSB];
    // Constant field is consumed by the datapath only
    assign unused_ir = ^IR[RC_LSB-1:C_LSB];

`ifdef CS_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    // Instruction boundary: halt here if a stop request is pending
    assign inst_end = stop ? ST_HALT : ST_T0;

    // Opcode classification and ALU operation for the execute phase
    always_comb begin
        op_cls   = CL_ILL;
        alu_code = ALU_ADD;
        case (op)
            OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND), OPW'(OP_OR),
            OPW'(OP_SHR), OPW'(OP_SHL), OPW'(OP_ROR), OPW'(OP_ROL): begin
                op_cls   = CL_ALU;
                alu_code = ALU_W'(op);
            end
            OPW'(OP_ADDI): begin op_cls = CL_IMM; alu_code = ALU_ADD; end
            OPW'(OP_ANDI): begin op_cls = CL_IMM; alu_code = ALU_AND; end
            OPW'(OP_ORI):  begin op_cls = CL_IMM; alu_code = ALU_OR;  end
            OPW'(OP_LDI):  op_cls = CL_LDI;
            OPW'(OP_LD):   op_cls = CL_LD;
            OPW'(OP_ST):   op_cls = CL_ST;
            OPW'(OP_MUL):  begin op_cls = CL_MULDIV; alu_code = ALU_MUL; end
            OPW'(OP_DIV):  begin op_cls = CL_MULDIV; alu_code = ALU_DIV; end
            OPW'(OP_MFHI): op_cls = CL_MFHI;
            OPW'(OP_MFLO): op_cls = CL_MFLO;
            OPW'(OP_NOP):  op_cls = CL_NOP;
            OPW'(OP_HALT): op_cls = CL_HALT;
            default:       op_cls = CL_ILL;
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobe decode
    always_comb begin
        state_d    = state_q;
        PCout      = 1'b0;
        PC_in      = 1'b0;
        Inc_PC     = 1'b0;
        MAR_in     = 1'b0;
        MDR_in     = 1'b0;
        MDRout     = 1'b0;
        IR_in      = 1'b0;
        Y_in       = 1'b0;
        Z_in       = 1'b0;
        ZLOWout    = 1'b0;
        ZHIout     = 1'b0;
        HI_in      = 1'b0;
        LO_in      = 1'b0;
        HIout      = 1'b0;
        LOout      = 1'b0;
        Cout       = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        ALU_select = '0;
        illegal_op = 1'b0;
        rin_en     = 1'b0;
        rin_sel    = ra;
        rout_en    = 1'b0;
        rout_sel   = rb;
        run        = (state_q != ST_RST) && (state_q != ST_HALT);

        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0: begin
                PCout  = 1'b1;
                MAR_in = 1'b1;
                Inc_PC = 1'b1;
                Z_in   = 1'b1;
                state_d = ST_T1;
            end
            ST_T1: begin
                ZLOWout = 1'b1;
                PC_in   = 1'b1;
                read    = 1'b1;
                MDR_in  = 1'b1;
                if (mem_ok) state_d = ST_T2;
            end
            ST_T2: begin
                MDRout  = 1'b1;
                IR_in   = 1'b1;
                state_d = (op_cls == CL_NOP) ? inst_end : ST_T3;
            end
            ST_T3: begin
                case (op_cls)
                    CL_ALU, CL_IMM, CL_LDI, CL_LD, CL_ST: begin
                        rout_en  = 1'b1;
                        rout_sel = rb;
                        Y_in     = 1'b1;
                        state_d  = ST_T4;
                    end
                    CL_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_sel = ra;
                        Y_in     = 1'b1;
                        state_d  = ST_T4;
                    end
                    CL_MFHI: begin
                        HIout   = 1'b1;
                        rin_en  = 1'b1;
                        state_d = inst_end;
                    end
                    CL_MFLO: begin
                        LOout   = 1'b1;
                        rin_en  = 1'b1;
                        state_d = inst_end;
                    end
                    CL_HALT: state_d = ST_HALT;
                    CL_NOP:  state_d = inst_end;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = inst_end;
                    end
                endcase
            end
            ST_T4: begin
                Z_in       = 1'b1;
                ALU_select = alu_code;
                state_d    = ST_T5;
                case (op_cls)
                    CL_ALU: begin
                        rout_en  = 1'b1;
                        rout_sel = rc;
                    end
                    CL_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_sel = rb;
                    end
                    default: Cout = 1'b1;
                endcase
            end
            ST_T5: begin
                ZLOWout = 1'b1;
                case (op_cls)
                    CL_LD, CL_ST: begin
                        MAR_in  = 1'b1;
                        state_d = ST_T6;
                    end
                    CL_MULDIV: begin
                        LO_in   = 1'b1;
                        state_d = ST_T6;
                    end
                    default: begin
                        rin_en  = 1'b1;
                        state_d = inst_end;
                    end
                endcase
            end
            ST_T6: begin
                case (op_cls)
                    CL_MULDIV: begin
                        ZHIout  = 1'b1;
                        HI_in   = 1'b1;
                        state_d = inst_end;
                    end
                    CL_ST: begin
                        rout_en  = 1'b1;
                        rout_sel = ra;
                        MDR_in   = 1'b1;
                        state_d  = ST_T7;
                    end
                    default: begin
                        read   = 1'b1;
                        MDR_in = 1'b1;
                        if (mem_ok) state_d = ST_T7;
                    end
                endcase
            end
            ST_T7: begin
                if (op_cls == CL_ST) begin
                    write = 1'b1;
                    if (mem_ok) state_d = inst_end;
                end else begin
                    MDRout  = 1'b1;
                    rin_en  = 1'b1;
                    state_d = inst_end;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    // Register load strobes
    reg_select_decoder #(.NREGS(NREGS), .SEL_W(REGSEL_W)) u_rin_dec (
        .sel_i    (rin_sel),
        .en_i     (rin_en),
        .onehot_o (r_in)
    );

    // Register bus-drive strobes
    reg_select_decoder #(.NREGS(NREGS), .SEL_W(REGSEL_W)) u_rout_dec (
        .sel_i    (rout_sel),
        .en_i     (rout_en),
        .onehot_o (r_out)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: per-cycle strobe vectors per instruction.
module tb_control_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] IR;
    logic        stop;
    logic [15:0] r_in, r_out;
    logic        PCout, PC_in, Inc_PC, MAR_in, MDR_in, MDRout, IR_in, Y_in, Z_in;
    logic        ZLOWout, ZHIout, HI_in, LO_in, HIout, LOout, Cout;
    logic        read, write, run, illegal_op;
    logic [3:0]  ALU_select;
`ifdef CS_MEM_WAIT_EN
    logic        mem_ready;
    assign mem_ready = 1'b1;
`endif

    int checks;
    int errors;

    control_sequencer #(.NREGS(16), .OPW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef CS_MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .IR         (IR),
        .stop       (stop),
        .r_in       (r_in),
        .r_out      (r_out),
        .PCout      (PCout),
        .PC_in      (PC_in),
        .Inc_PC     (Inc_PC),
        .MAR_in     (MAR_in),
        .MDR_in     (MDR_in),
        .MDRout     (MDRout),
        .IR_in      (IR_in),
        .Y_in       (Y_in),
        .Z_in       (Z_in),
        .ZLOWout    (ZLOWout),
        .ZHIout     (ZHIout),
        .HI_in      (HI_in),
        .LO_in      (LO_in),
        .HIout      (HIout),
        .LOout      (LOout),
        .Cout       (Cout),
        .read       (read),
        .write      (write),
        .ALU_select (ALU_select),
        .run        (run),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit positions of the single-bit outputs in the observed vector
    localparam logic [19:0] P_PCOUT  = 20'h80000;
    localparam logic [19:0] P_PCIN   = 20'h40000;
    localparam logic [19:0] P_INC    = 20'h20000;
    localparam logic [19:0] P_MAR    = 20'h10000;
    localparam logic [19:0] P_MDRIN  = 20'h08000;
    localparam logic [19:0] P_MDROUT = 20'h04000;
    localparam logic [19:0] P_IRIN   = 20'h02000;
    localparam logic [19:0] P_YIN    = 20'h01000;
    localparam logic [19:0] P_ZIN    = 20'h00800;
    localparam logic [19:0] P_ZLOW   = 20'h00400;
    localparam logic [19:0] P_ZHI    = 20'h00200;
    localparam logic [19:0] P_HIIN   = 20'h00100;
    localparam logic [19:0] P_LOIN   = 20'h00080;
    localparam logic [19:0] P_HIOUT  = 20'h00040;
    localparam logic [19:0] P_LOOUT  = 20'h00020;
    localparam logic [19:0] P_COUT   = 20'h00010;
    localparam logic [19:0] P_READ   = 20'h00008;
    localparam logic [19:0] P_WRITE  = 20'h00004;
    localparam logic [19:0] P_RUN    = 20'h00002;
    localparam logic [19:0] P_ILL    = 20'h00001;

    // Observed vector: {strobes[19:0], r_in, r_out, ALU_select}
    logic [55:0] obs;
    assign obs = {PCout, PC_in, Inc_PC, MAR_in, MDR_in, MDRout, IR_in, Y_in, Z_in,
                  ZLOWout, ZHIout, HI_in, LO_in, HIout, LOout, Cout,
                  read, write, run, illegal_op, r_in, r_out, ALU_select};

    localparam logic [55:0] F0 = {P_PCOUT | P_MAR | P_INC | P_ZIN | P_RUN, 16'h0, 16'h0, 4'h0};
    localparam logic [55:0] F1 = {P_ZLOW | P_PCIN | P_READ | P_MDRIN | P_RUN, 16'h0, 16'h0, 4'h0};
    localparam logic [55:0] F2 = {P_MDROUT | P_IRIN | P_RUN, 16'h0, 16'h0, 4'h0};
    localparam logic [55:0] ZERO = 56'h0;

    function automatic logic [55:0] ex(input logic [19:0] s, input logic [15:0] ri,
                                       input logic [15:0] ro, input logic [3:0] a);
        return {s, ri, ro, a};
    endfunction

    // Hold reset for a cycle with the given IR/stop, release on a falling edge
    task automatic do_reset(input logic [31:0] ir, input logic stp);
        @(negedge clk);
        rst_n = 1'b0;
        IR    = ir;
        stop  = stp;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (obs !== ZERO) begin
            errors++;
            $display("FAIL reset_async got %h want %h", obs, ZERO);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== ZERO) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %h want %h", i, obs, ZERO);
            end
        end
    endtask

    task automatic test_and;
        logic [55:0] e [7];
        e = '{F0, F1, F2,
              ex(P_YIN | P_RUN, 16'h0, 16'h0004, 4'h0),
              ex(P_ZIN | P_RUN, 16'h0, 16'h0010, 4'h5),
              ex(P_ZLOW | P_RUN, 16'h0020, 16'h0, 4'h0),
              F0};
        do_reset(32'h2A920000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL and_r5_r2_r4 cyc %0d got %h want %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_ld;
        logic [55:0] e [9];
        e = '{F0, F1, F2,
              ex(P_YIN | P_RUN, 16'h0, 16'h0001, 4'h0),
              ex(P_COUT | P_ZIN | P_RUN, 16'h0, 16'h0, 4'h3),
              ex(P_ZLOW | P_MAR | P_RUN, 16'h0, 16'h0, 4'h0),
              ex(P_READ | P_MDRIN | P_RUN, 16'h0, 16'h0, 4'h0),
              ex(P_MDROUT | P_RUN, 16'h0002, 16'h0, 4'h0),
              F0};
        do_reset(32'h00800055, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL ld_r1 cyc %0d got %h want %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_st;
        logic [55:0] e [9];
        e = '{F0, F1, F2,
              ex(P_YIN | P_RUN, 16'h0, 16'h0001, 4'h0),
              ex(P_COUT | P_ZIN | P_RUN, 16'h0, 16'h0, 4'h3),
              ex(P_ZLOW | P_MAR | P_RUN, 16'h0, 16'h0, 4'h0),
              ex(P_MDRIN | P_RUN, 16'h0, 16'h0002, 4'h0),
              ex(P_WRITE | P_RUN, 16'h0, 16'h0, 4'h0),
              F0};
        do_reset(32'h10800055, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL st_r1 cyc %0d got %h want %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_mul;
        logic [55:0] e [8];
        e = '{F0, F1, F2,
              ex(P_YIN | P_RUN, 16'h0, 16'h0008, 4'h0),
              ex(P_ZIN | P_RUN, 16'h0, 16'h0010, 4'hB),
              ex(P_ZLOW | P_LOIN | P_RUN, 16'h0, 16'h0, 4'h0),
              ex(P_ZHI | P_HIIN | P_RUN, 16'h0, 16'h0, 4'h0),
              F0};
        do_reset(32'h71A00000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL mul_r3_r4 cyc %0d got %h want %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_mfhi_nop;
        logic [55:0] e [5];
        logic [55:0] n [4];
        e = '{F0, F1, F2, ex(P_HIOUT | P_RUN, 16'h0080, 16'h0, 4'h0), F0};
        n = '{F0, F1, F2, F0};
        do_reset(32'hC3800000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL mfhi_r7 cyc %0d got %h want %h", i, obs, e[i]);
            end
        end
        do_reset(32'hD0000000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== n[i]) begin
                errors++;
                $display("FAIL nop cyc %0d got %h want %h", i, obs, n[i]);
            end
        end
    endtask

    task automatic test_illegal;
        logic [55:0] e [6];
        e = '{F0, F1, F2, ex(P_RUN | P_ILL, 16'h0, 16'h0, 4'h0), F0, F1};
        do_reset(32'hF8000000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL illegal_op cyc %0d got %h want %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_stop;
        logic [55:0] e [9];
        e = '{F0, F1, F2,
              ex(P_YIN | P_RUN, 16'h0, 16'h0004, 4'h0),
              ex(P_ZIN | P_RUN, 16'h0, 16'h0010, 4'h5),
              ex(P_ZLOW | P_RUN, 16'h0020, 16'h0, 4'h0),
              ZERO, ZERO, ZERO};
        do_reset(32'h2A920000, 1'b1);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL stop_halt cyc %0d got %h want %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_halt;
        logic [55:0] e [4];
        e = '{F0, F1, F2, ex(P_RUN, 16'h0, 16'h0, 4'h0)};
        do_reset(32'hD8000000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL halt_seq cyc %0d got %h want %h", i, obs, e[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== ZERO) begin
                errors++;
                $display("FAIL halt_idle cyc %0d got %h want %h", i, obs, ZERO);
            end
        end
        do_reset(32'hD8000000, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (obs !== F0) begin
            errors++;
            $display("FAIL halt_restart got %h want %h", obs, F0);
        end
    endtask

    task automatic test_reset_mid;
        logic [55:0] e [5];
        e = '{F0, F1, F2,
              ex(P_YIN | P_RUN, 16'h0, 16'h0004, 4'h0),
              ex(P_ZIN | P_RUN, 16'h0, 16'h0010, 4'h5)};
        do_reset(32'h2A920000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL mid_pre cyc %0d got %h want %h", i, obs, e[i]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== ZERO) begin
            errors++;
            $display("FAIL mid_t4_reset got %h want %h", obs, ZERO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== F0) begin
            errors++;
            $display("FAIL mid_restart got %h want %h", obs, F0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        IR     = 32'h0;
        stop   = 1'b0;
        test_reset();
        test_and();
        test_ld();
        test_st();
        test_mul();
        test_mfhi_nop();
        test_illegal();
        test_stop();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit driving every control input of the existing datapath: register-select strobes, bus-drive enables, ALU_select, memory read/write.
- Replaces hand-sequenced bench stimulus: fetches the instruction, decodes IR, and steps the T-state sequence until halt.
- Sits beside the datapath; its outputs connect one-to-one to the datapath control pins.

Parameters:
- NREGS, 16, general registers (r_in/r_out width).
- OPW, 5, opcode width (IR[31:27]).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IR  in  32  instruction register contents from datapath.
- stop  in  1  request halt at next instruction boundary.
- r_in  out  NREGS  one-hot register load.
- r_out  out  NREGS  one-hot register bus drive.
- PCout, PC_in, Inc_PC, MAR_in, MDR_in, MDRout, IR_in, Y_in, Z_in, ZLOWout, ZHIout, HI_in, LO_in, HIout, LOout, Cout  out  1 each  datapath strobes.
- read, write  out  1 each  memory controls.
- ALU_select  out  4  ALU operation.
- run  out  1  high while executing.
- illegal_op  out  1  one-cycle pulse on undefined opcode.

Behaviour:
- Reset: async active-low; every output 0 immediately, state=RST. Any state, mid-instruction included: abort, no completion. First posedge after release -> T0.
- Moore outputs: decoded from state register plus IR fields; change only after posedge. run=1 in every state except RST and HALT.
- IR fields: op=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15], C=IR[18:0] (sign extension done in datapath under Cout).
- Fetch, all instructions:
  - T0: PCout, MAR_in, Inc_PC, Z_in.
  - T1: ZLOWout, PC_in, read, MDR_in.
  - T2: MDRout, IR_in.
- Execute:
  - ALU R-type, op 00011-01010 (add sub and or shr shl ror rol), ALU_select=op[3:0]:
    - T3: r_out[rb], Y_in.
    - T4: r_out[rc], ALU_select, Z_in.
    - T5: ZLOWout, r_in[ra].
  - Immediate (addi 01011->0011, andi 01100->0101, ori 01101->0110): as R-type, but T4 drives Cout instead of r_out[rc].
  - ldi 00001: T3 r_out[rb], Y_in; T4 Cout, ALU_select=0011, Z_in; T5 ZLOWout, r_in[ra].
  - ld 00000: T3/T4 as ldi; T5 ZLOWout, MAR_in; T6 read, MDR_in; T7 MDRout, r_in[ra].
  - st 00010: T3/T4 as ldi; T5 ZLOWout, MAR_in; T6 r_out[ra], MDR_in (read=0); T7 write.
  - mul 01110 (ALU 1011), div 01111 (ALU 1100): T3 r_out[ra], Y_in; T4 r_out[rb], ALU_select, Z_in; T5 ZLOWout, LO_in; T6 ZHIout, HI_in.
  - mfhi 11000 / mflo 11001: T3 HIout/LOout, r_in[ra].
  - nop 11010: returns to T0 after T2.
  - halt 11011: T3 -> HALT.
  - Undefined op: illegal_op=1 during T3, then T0 (treated as nop).
- Last execute state -> T0, unless stop was sampled high at that edge -> HALT.
- HALT: all strobes 0, run=0; exits only via rst_n.
- At most one r_out bit set per cycle. r_out and r_in are never asserted in the same cycle except mfhi/mflo (r_in only).

Optional Feature:
- CS_MEM_WAIT_EN defined:
  - Adds input mem_ready (1 bit).
  - States T1, ld-T6, st-T7 hold, outputs unchanged, until mem_ready=1 is sampled at posedge.
  - Reset still overrides.
- Undefined: no port; every memory state lasts exactly one cycle.

Decomposition:
- Package cs_pkg:
  - opcode localparams.
  - ALU_select codes: ADD 0011, SUB 0100, AND 0101, OR 0110, SHR 0111, SHL 1000, ROR 1001, ROL 1010, MUL 1011, DIV 1100.
  - state enum: RST, T0-T7, HALT.
  - IR field bit positions.
- Sub-module reg_select_decoder: 4-bit field plus enable -> one-hot NREGS vector; instantiated for r_in and r_out.

Test Plan:
- Release rst_n -> cycle 1 PCout=MAR_in=Inc_PC=Z_in=1; cycle 2 ZLOWout=PC_in=read=MDR_in=1; cycle 3 MDRout=IR_in=1.
- IR=0x2A920000 (and R5,R2,R4):
  - T3: r_out=0x0004, Y_in=1.
  - T4: r_out=0x0010, ALU_select=0101, Z_in=1.
  - T5: ZLOWout=1, r_in=0x0020.
  - Next cycle: T0.
- IR=0x00800055 (ld R1,0x55(R0)):
  - T4: Cout=1, ALU_select=0011.
  - T5: MAR_in=1.
  - T6: read=MDR_in=1.
  - T7: MDRout=1, r_in=0x0002.
  - 8 cycles total.
- IR=0x71A00000 (mul R3,R4):
  - T3: r_out=0x0008.
  - T4: r_out=0x0010, ALU_select=1011.
  - T5: LO_in=1.
  - T6: ZHIout=HI_in=1.
- IR=0xD8000000 (halt) -> run=0 and all strobes 0 for 10 cycles. Pulse rst_n low, release -> fetch resumes at T0.
- rst_n low mid-T4 -> all outputs 0 before next edge. IR=0xF8000000 -> illegal_op pulse exactly one cycle in T3.
